// File: rtl/func_unit_arbiter_if.sv
// func_unit_arbiter_if: requester, response and FU handshake signals of the shared-FU arbiter
//  master: arbiter side (drives req_ready, rsp_*, fu_req_valid, fu_arg)
//  slave : requesters plus FU (drive req_valid, req_arg, rsp_ready, fu_req_ready, fu_rsp_*)
interface func_unit_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_arg;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [W-1:0]      rsp_data;
   logic              rsp_err;
   logic              fu_req_valid;
   logic              fu_req_ready;
   logic [W-1:0]      fu_arg;
   logic              fu_rsp_valid;
   logic [W-1:0]      fu_rsp_data;
   modport master (
      input  req_valid, req_arg, rsp_ready, fu_req_ready, fu_rsp_valid, fu_rsp_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, fu_req_valid, fu_arg
   );
   modport slave (
      output req_valid, req_arg, rsp_ready, fu_req_ready, fu_rsp_valid, fu_rsp_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, fu_req_valid, fu_arg
   );
endinterface

// File: rtl/func_unit_arbiter.sv
// func_unit_arbiter: round-robin sharing of one function unit among NREQ requesters, one op in flight
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  bus        : func_unit_arbiter_if.master (req_valid/req_arg/req_ready, rsp_valid/rsp_ready/rsp_data/rsp_err,
//               fu_req_valid/fu_req_ready/fu_arg, fu_rsp_valid/fu_rsp_data)
//  FUNC_ARB_TIMEOUT_EN : when defined, an op whose FU result has not arrived TIMEOUT cycles after issue
//               completes with rsp_err=1 and rsp_data=0
module func_unit_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   func_unit_arbiter_if.master bus
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, pick;
   logic [W-1:0] arg_q, arg_d, data_q, data_d;
   logic [IW:0] sum;
   logic any;
`ifdef FUNC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
`endif
   // Scan from the farthest offset down so the nearest requester at or after ptr wins.
   always_comb begin
      any  = 1'b0;
      pick = '0;
      sum  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
         if (bus.req_valid[sum[IW-1:0]]) begin
            any  = 1'b1;
            pick = sum[IW-1:0];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      arg_d   = arg_q;
      data_d  = data_q;
`ifdef FUNC_ARB_TIMEOUT_EN
      cnt_d   = (state_q == IDLE) ? '0 : cnt_q;
      err_d   = (state_q == RESP) ? err_q : 1'b0;
`endif
      case (state_q)
         IDLE: if (any) begin
            g_d     = pick;
            arg_d   = bus.req_arg[int'(pick)*W +: W];
            state_d = ISSUE;
         end
         // A zero-latency FU may return its result in the issue handshake cycle.
         ISSUE: if (bus.fu_req_ready) begin
            state_d = bus.fu_rsp_valid ? RESP : WAIT;
            data_d  = bus.fu_rsp_valid ? bus.fu_rsp_data : data_q;
         end
         WAIT: if (bus.fu_rsp_valid) begin
            state_d = RESP;
            data_d  = bus.fu_rsp_data;
         end
         RESP: if (bus.rsp_ready[g_q]) begin
            ptr_d   = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef FUNC_ARB_TIMEOUT_EN
      if ((state_q == ISSUE || state_q == WAIT) && state_d != RESP) begin
         if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
      end
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         arg_q   <= '0;
         data_q  <= '0;
`ifdef FUNC_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         arg_q   <= arg_d;
         data_q  <= data_d;
`ifdef FUNC_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end
   // The accept pulse is combinational in the grant cycle; gated so it stays low while reset is held.
   assign bus.req_ready    = (state_q == IDLE && any && rst_n) ? NREQ'(1) << pick : '0;
   assign bus.rsp_valid    = (state_q == RESP) ? NREQ'(1) << g_q : '0;
   assign bus.rsp_data     = data_q;
   assign bus.fu_req_valid = state_q == ISSUE;
   assign bus.fu_arg       = (state_q == ISSUE) ? arg_q : '0;
`ifdef FUNC_ARB_TIMEOUT_EN
   assign bus.rsp_err      = err_q;
`else
   assign bus.rsp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_func_unit_arbiter.sv
// tb_func_unit_arbiter: self-checking bench for func_unit_arbiter with a delay-configurable FU model
module tb_func_unit_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int fails = 0;
   int m_ptr = 0;
   int acc_dly = 0;
   int rsp_dly = 1;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   bit fu_rsp_en = 1'b1;
   logic [W-1:0] key = '0;
   logic [W-1:0] fu_held = '0;
   logic [NREQ-1:0] pend = '0;
   logic [W-1:0] args [NREQ];
   func_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
   func_unit_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   // FU model: accepts acc_dly cycles after fu_req_valid rises, answers arg^key rsp_dly cycles after accept
   // (0 = same cycle); an already scheduled answer is delivered even if the arbiter was reset meanwhile.
   initial begin
      bus.fu_req_ready = 1'b0;
      bus.fu_rsp_valid = 1'b0;
      bus.fu_rsp_data  = '0;
      forever begin
         @(negedge clk);
         bus.fu_req_ready = 1'b0;
         bus.fu_rsp_valid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.fu_rsp_valid = fu_rsp_en;
               bus.fu_rsp_data  = fu_held ^ key;
            end
         end else if (!bus.fu_req_valid) acc_cnt = 0;
         else if (acc_cnt < acc_dly) acc_cnt++;
         else begin
            acc_cnt = 0;
            bus.fu_req_ready = 1'b1;
            fu_held = bus.fu_arg;
            if (rsp_dly == 0) begin
               bus.fu_rsp_valid = fu_rsp_en;
               bus.fu_rsp_data  = bus.fu_arg ^ key;
            end else rsp_cnt = rsp_dly;
         end
      end
   end
   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction
   task automatic wait_for(input bit rsp, output int n);
      n = 0;
      while (n < 100 && ((rsp ? bus.rsp_valid : bus.req_ready) == '0)) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
   endtask
   task automatic test_reset();
      bus.req_valid = '0;
      bus.req_arg   = '0;
      bus.rsp_ready = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid} !== '0) begin
         fails++;
         $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, want 0", bus.req_ready, bus.rsp_valid);
      end
      checks++;
      if ({bus.rsp_data, bus.rsp_err} !== '0) begin
         fails++;
         $display("FAIL reset_rsp: rsp_data=%h rsp_err=%b, want 0", bus.rsp_data, bus.rsp_err);
      end
      checks++;
      if ({bus.fu_req_valid, bus.fu_arg} !== '0) begin
         fails++;
         $display("FAIL reset_fu: fu_req_valid=%b fu_arg=%h, want 0", bus.fu_req_valid, bus.fu_arg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
   endtask
   task automatic test_single();
      int n;
      key = '0; acc_dly = 0; rsp_dly = 1;
      @(negedge clk);
      bus.rsp_ready = '1;
      bus.req_arg[0 +: W] = 8'h5A;
      bus.req_valid = 4'b0001;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL single_grant: req_ready=%b, want 0001", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      wait_for(1'b1, n);
      checks++;
      if (n + 1 != 3) begin
         fails++;
         $display("FAIL single_latency: %0d cycles, want 3", n + 1);
      end
      checks++;
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 8'h5A || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp: rsp_valid=%b data=%h err=%b, want 0001/5a/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
      end
      m_ptr = 1;
      @(negedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== '0) begin
         fails++;
         $display("FAIL single_done: rsp_valid=%b after completion, want 0", bus.rsp_valid);
      end
   endtask
   task automatic test_round_robin();
      int n;
      int ord [5] = '{0, 1, 2, 3, 0};
      apply_reset();
      key = 8'h3C; acc_dly = 0; rsp_dly = 1;
      bus.rsp_ready = '1;
      for (int i = 0; i < NREQ; i++) bus.req_arg[i*W +: W] = 8'(8'h10 + i);
      bus.req_valid = '1;
      #1;
      for (int op = 0; op < 5; op++) begin
         wait_for(1'b0, n);
         checks++;
         if (bus.req_ready !== (NREQ'(1) << ord[op])) begin
            fails++;
            $display("FAIL rr_grant%0d: req_ready=%b, want index %0d", op, bus.req_ready, ord[op]);
         end
         wait_for(1'b1, n);
         checks++;
         if (bus.rsp_valid !== (NREQ'(1) << ord[op]) || bus.rsp_data !== (8'(8'h10 + ord[op]) ^ key)) begin
            fails++;
            $display("FAIL rr_rsp%0d: rsp_valid=%b data=%h, want index %0d data %h", op, bus.rsp_valid,
                     bus.rsp_data, ord[op], 8'(8'h10 + ord[op]) ^ key);
         end
         m_ptr = (ord[op] + 1) % NREQ;
         if (op == 4) bus.req_valid = '0;
         @(negedge clk);
         #1;
      end
   endtask
   task automatic test_slow_fu();
      int lat, issue_cyc, arg_bad, extra, e;
      key = 8'h81; acc_dly = 5; rsp_dly = 7;
      @(negedge clk);
      bus.rsp_ready = '1;
      bus.req_arg[0 +: W] = 8'h77;
      bus.req_arg[2*W +: W] = 8'hC7;
      bus.req_valid = 4'b0101;
      #1;
      e = pick(4'b0101, m_ptr);
      checks++;
      if (bus.req_ready !== (NREQ'(1) << e)) begin
         fails++;
         $display("FAIL slow_grant: req_ready=%b, want index %0d", bus.req_ready, e);
      end
      @(negedge clk);
      bus.req_valid = 4'b0001;
      #1;
      lat = 1; issue_cyc = 0; arg_bad = 0; extra = 0;
      while (bus.rsp_valid == '0 && lat < 60) begin
         if (bus.fu_req_valid) begin
            issue_cyc++;
            if (bus.fu_arg !== 8'hC7) arg_bad++;
         end
         if (bus.req_ready != '0) extra++;
         @(negedge clk);
         #1;
         lat++;
      end
      bus.req_valid = '0;
      checks++;
      if (lat != 14 || issue_cyc != 6) begin
         fails++;
         $display("FAIL slow_timing: latency=%0d issue_cycles=%0d, want 14/6", lat, issue_cyc);
      end
      checks++;
      if (arg_bad != 0 || extra != 0) begin
         fails++;
         $display("FAIL slow_stable: fu_arg changes=%0d extra req_ready=%0d, want 0/0", arg_bad, extra);
      end
      checks++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== (8'hC7 ^ 8'h81)) begin
         fails++;
         $display("FAIL slow_rsp: rsp_valid=%b data=%h, want 0100/%h", bus.rsp_valid, bus.rsp_data, 8'hC7 ^ 8'h81);
      end
      m_ptr = 3;
      @(negedge clk);
   endtask
   task automatic test_stall();
      int n, bad, e, e2;
      key = 8'h5E; acc_dly = 0; rsp_dly = 1;
      @(negedge clk);
      bus.rsp_ready = '0;
      bus.req_arg[1*W +: W] = 8'h21;
      bus.req_arg[3*W +: W] = 8'h43;
      bus.req_valid = 4'b1010;
      #1;
      e = pick(4'b1010, m_ptr);
      checks++;
      if (bus.req_ready !== (NREQ'(1) << e)) begin
         fails++;
         $display("FAIL stall_grant: req_ready=%b, want index %0d", bus.req_ready, e);
      end
      @(negedge clk);
      bus.req_valid[e] = 1'b0;
      #1;
      wait_for(1'b1, n);
      checks++;
      if (bus.rsp_valid !== (NREQ'(1) << e) || bus.rsp_data !== (args_of(e) ^ key)) begin
         fails++;
         $display("FAIL stall_rsp: rsp_valid=%b data=%h, want index %0d data %h", bus.rsp_valid, bus.rsp_data,
                  e, args_of(e) ^ key);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.rsp_ready = 4'($urandom) & ~(NREQ'(1) << e);
         #1;
         if (bus.rsp_valid !== (NREQ'(1) << e) || bus.rsp_data !== (args_of(e) ^ key) || bus.req_ready !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stall_hold: %0d cycles changed or granted while stalled, want 0", bad);
      end
      @(negedge clk);
      bus.rsp_ready = NREQ'(1) << e;
      m_ptr = (e + 1) % NREQ;
      @(negedge clk);
      #1;
      e2 = pick(bus.req_valid, m_ptr);
      checks++;
      if (bus.rsp_valid !== '0 || bus.req_ready !== (NREQ'(1) << e2)) begin
         fails++;
         $display("FAIL stall_release: rsp_valid=%b req_ready=%b, want 0 and index %0d", bus.rsp_valid,
                  bus.req_ready, e2);
      end
      @(negedge clk);
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      #1;
      wait_for(1'b1, n);
      checks++;
      if (bus.rsp_valid !== (NREQ'(1) << e2) || bus.rsp_data !== (args_of(e2) ^ key)) begin
         fails++;
         $display("FAIL stall_next: rsp_valid=%b data=%h, want index %0d data %h", bus.rsp_valid, bus.rsp_data,
                  e2, args_of(e2) ^ key);
      end
      m_ptr = (e2 + 1) % NREQ;
      @(negedge clk);
      bus.rsp_ready = '0;
   endtask
   function automatic logic [W-1:0] args_of(input int i);
      return bus.req_arg[i*W +: W];
   endfunction
   task automatic test_reset_mid();
      int n, seen, e;
      key = 8'h99; acc_dly = 0; rsp_dly = 6;
      @(negedge clk);
      bus.rsp_ready = '1;
      bus.req_arg[2*W +: W] = 8'hE1;
      bus.req_valid = 4'b0100;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0100) begin
         fails++;
         $display("FAIL rmid_grant: req_ready=%b, want 0100", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.fu_req_valid, bus.fu_arg} !== '0) begin
         fails++;
         $display("FAIL rmid_outputs: req_ready=%b rsp_valid=%b data=%h err=%b fu_req_valid=%b fu_arg=%h, want 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.fu_req_valid, bus.fu_arg);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (bus.rsp_valid != '0 || bus.fu_req_valid || bus.rsp_data != '0) seen++;
      end
      checks++;
      if (seen != 0) begin
         fails++;
         $display("FAIL rmid_late_rsp: %0d cycles reacted to stale FU result, want 0", seen);
      end
      rsp_dly = 1;
      for (int i = 0; i < NREQ; i++) bus.req_arg[i*W +: W] = 8'(8'hA0 + i);
      bus.req_valid = '1;
      #1;
      e = pick(4'b1111, m_ptr);
      checks++;
      if (bus.req_ready !== (NREQ'(1) << e)) begin
         fails++;
         $display("FAIL rmid_ptr: req_ready=%b, want index %0d", bus.req_ready, e);
      end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      wait_for(1'b1, n);
      checks++;
      if (bus.rsp_valid !== (NREQ'(1) << e) || bus.rsp_data !== (8'(8'hA0 + e) ^ key)) begin
         fails++;
         $display("FAIL rmid_rsp: rsp_valid=%b data=%h, want index %0d data %h", bus.rsp_valid, bus.rsp_data,
                  e, 8'(8'hA0 + e) ^ key);
      end
      m_ptr = (e + 1) % NREQ;
      @(negedge clk);
   endtask
   task automatic test_timeout();
      int n, e;
      fu_rsp_en = 1'b0; acc_dly = 0; rsp_dly = 1;
      @(negedge clk);
      bus.rsp_ready = '1;
      bus.req_arg[1*W +: W] = 8'h6B;
      bus.req_valid = 4'b0010;
      #1;
      e = pick(4'b0010, m_ptr);
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         fails++;
         $display("FAIL to_grant: req_ready=%b, want 0010", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      wait_for(1'b1, n);
`ifdef FUNC_ARB_TIMEOUT_EN
      checks++;
      if (n + 1 != 17) begin
         fails++;
         $display("FAIL to_latency: %0d cycles, want 17", n + 1);
      end
      checks++;
      if (bus.rsp_valid !== (NREQ'(1) << e) || bus.rsp_data !== '0 || bus.rsp_err !== 1'b1) begin
         fails++;
         $display("FAIL to_rsp: rsp_valid=%b data=%h err=%b, want 0010/00/1", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
      end
      m_ptr = (e + 1) % NREQ;
      @(negedge clk);
      fu_rsp_en = 1'b1;
`else
      checks++;
      if (bus.rsp_valid !== '0 || bus.fu_req_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL to_hold: rsp_valid=%b fu_req_valid=%b err=%b after %0d cycles, want 0/0/0", bus.rsp_valid,
                  bus.fu_req_valid, bus.rsp_err, n);
      end
      fu_rsp_en = 1'b1;
      apply_reset();
`endif
   endtask
   task automatic test_random();
      int n, e, lat;
      for (int op = 0; op < 40; op++) begin
         @(negedge clk);
         bus.rsp_ready = '0;
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               args[i] = 8'($urandom);
            end
         if (pend == '0) begin
            pend[op % NREQ] = 1'b1;
            args[op % NREQ] = 8'($urandom);
         end
         for (int i = 0; i < NREQ; i++) bus.req_arg[i*W +: W] = args[i];
         bus.req_valid = pend;
         acc_dly = $urandom_range(0, 3);
         rsp_dly = $urandom_range(0, 3);
         key = 8'($urandom);
         #1;
         e = pick(pend, m_ptr);
         lat = acc_dly + 2 + rsp_dly;
         checks++;
         if (bus.req_ready !== (NREQ'(1) << e)) begin
            fails++;
            $display("FAIL rnd_grant%0d: req_ready=%b pend=%b ptr=%0d, want index %0d", op, bus.req_ready, pend, m_ptr, e);
         end
         @(negedge clk);
         pend[e] = 1'b0;
         bus.req_valid = pend;
         #1;
         wait_for(1'b1, n);
         checks++;
         if (n + 1 != lat) begin
            fails++;
            $display("FAIL rnd_latency%0d: %0d cycles, want %0d", op, n + 1, lat);
         end
         checks++;
         if (bus.rsp_valid !== (NREQ'(1) << e) || bus.rsp_data !== (args[e] ^ key) || bus.rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL rnd_rsp%0d: rsp_valid=%b data=%h err=%b, want index %0d data %h err 0", op, bus.rsp_valid,
                     bus.rsp_data, bus.rsp_err, e, args[e] ^ key);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         bus.rsp_ready = 4'($urandom) | (NREQ'(1) << e);
         m_ptr = (e + 1) % NREQ;
      end
      @(negedge clk);
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      pend = '0;
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_slow_fu();
      test_stall();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
